// File: rtl/hwt_sweep_ctrl.sv
// hwt_sweep_ctrl: self-test sequencer for the 4-input hwt cell
// (Y = D & (C ^ (A & B))). A start pulse walks the cell through all
// 16 input vectors in ascending order. Each vector is held for SETTLE
// cycles, and the cell output is sampled on the last cycle of each hold.
// The block collects a 16-bit response signature and compares it
// against the EXPECTED truth table.
module hwt_sweep_ctrl #(
  parameter logic [15:0] EXPECTED = 16'h7800,
  parameter int unsigned SETTLE   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        hwt_y,
  output logic        hwt_a,
  output logic        hwt_b,
  output logic        hwt_c,
  output logic        hwt_d,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature,
  output logic [4:0]  fail_count,
  output logic [3:0]  first_fail
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Settle counter value on which the sample edge falls
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 32'd1);
  localparam logic [3:0] LAST_VEC    = 4'd15;
  localparam logic [4:0] FAIL_MAX    = 5'd16;

  // Failure counter increment that never exceeds 16
  function automatic logic [4:0] sat_inc(input logic [4:0] cnt);
    logic [4:0] res;
    if (cnt >= FAIL_MAX) begin
      res = FAIL_MAX;
    end else begin
      res = cnt + 5'd1;
    end
    return res;
  endfunction

  // Golden response bit for one vector index
  function automatic logic golden_bit(input logic [3:0] v);
    return EXPECTED[v];
  endfunction

  state_t      state_r,      state_s;
  logic [3:0]  idx_r,        idx_s;
  logic [3:0]  settle_cnt_r, settle_cnt_s;
  logic [3:0]  vec_r,        vec_s;
  logic        busy_r,       busy_s;
  logic        done_r,       done_s;
  logic        pass_r,       pass_s;
  logic [15:0] signature_r,  signature_s;
  logic [4:0]  fail_count_r, fail_count_s;
  logic [3:0]  first_fail_r, first_fail_s;
  logic        miss_s;

  // Next-state and next-output computation for the sweep FSM
  always_comb begin
    state_s      = state_r;
    idx_s        = idx_r;
    settle_cnt_s = settle_cnt_r;
    vec_s        = vec_r;
    busy_s       = busy_r;
    done_s       = 1'b0;
    pass_s       = pass_r;
    signature_s  = signature_r;
    fail_count_s = fail_count_r;
    first_fail_s = first_fail_r;
    miss_s       = (hwt_y != golden_bit(idx_r));

    case (state_r)
      ST_IDLE: begin
        vec_s = 4'h0;
        if (start) begin
          // Accepting a start clears the results of the previous sweep
          state_s      = ST_RUN;
          busy_s       = 1'b1;
          idx_s        = 4'd0;
          settle_cnt_s = 4'd0;
          signature_s  = 16'h0000;
          fail_count_s = 5'd0;
          first_fail_s = 4'd0;
          pass_s       = 1'b0;
        end else begin
          state_s = ST_IDLE;
          busy_s  = 1'b0;
        end
      end

      ST_RUN: begin
        busy_s = 1'b1;
        if (settle_cnt_r == SETTLE_LAST) begin
          signature_s[idx_r] = hwt_y;
          if (miss_s) begin
            // A zero failure count means this is the first miss of the sweep
            if (fail_count_r == 5'd0) begin
              first_fail_s = idx_r;
            end else begin
              first_fail_s = first_fail_r;
            end
            fail_count_s = sat_inc(fail_count_r);
          end else begin
            fail_count_s = fail_count_r;
          end

          if (idx_r == LAST_VEC) begin
            // The pass verdict includes the bit sampled on this edge
            state_s      = ST_IDLE;
            busy_s       = 1'b0;
            done_s       = 1'b1;
            vec_s        = 4'h0;
            settle_cnt_s = 4'd0;
            pass_s       = (signature_s == EXPECTED);
          end else begin
            idx_s        = idx_r + 4'd1;
            vec_s        = idx_r + 4'd1;
            settle_cnt_s = 4'd0;
          end
        end else begin
          settle_cnt_s = settle_cnt_r + 4'd1;
          vec_s        = idx_r;
        end
      end

      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
        vec_s   = 4'h0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      idx_r        <= 4'd0;
      settle_cnt_r <= 4'd0;
      vec_r        <= 4'h0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
      signature_r  <= 16'h0000;
      fail_count_r <= 5'd0;
      first_fail_r <= 4'd0;
    end else begin
      state_r      <= state_s;
      idx_r        <= idx_s;
      settle_cnt_r <= settle_cnt_s;
      vec_r        <= vec_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      pass_r       <= pass_s;
      signature_r  <= signature_s;
      fail_count_r <= fail_count_s;
      first_fail_r <= first_fail_s;
    end
  end

  assign hwt_a      = vec_r[0];
  assign hwt_b      = vec_r[1];
  assign hwt_c      = vec_r[2];
  assign hwt_d      = vec_r[3];
  assign busy       = busy_r;
  assign done       = done_r;
  assign pass       = pass_r;
  assign signature  = signature_r;
  assign fail_count = fail_count_r;
  assign first_fail = first_fail_r;

endmodule

// File: tb/tb_hwt_sweep_ctrl.sv
// Directed bench for hwt_sweep_ctrl. It uses one instance with SETTLE=1
// and one with SETTLE=3, each driven by a behavioural hwt cell whose
// output can be forced to golden, stuck-at-0 or inverted behaviour.
module tb_hwt_sweep_ctrl;

  logic clk;
  logic rst;
  logic start1, start3;
  logic [1:0] mode1;
  logic glitch3;
  logic y1, y3;
  logic a1, b1, c1, d1, busy1, done1, pass1;
  logic a3, b3, c3, d3, busy3, done3, pass3;
  logic [15:0] sig1, sig3;
  logic [4:0] fc1, fc3;
  logic [3:0] ff1, ff3;
  logic [3:0] vec1, vec3;

  int total;
  int bad;

  // Behavioural hwt cell
  function automatic logic hwt_model(input logic [3:0] v);
    return v[3] & (v[2] ^ (v[1] & v[0]));
  endfunction

  assign vec1 = {d1, c1, b1, a1};
  assign vec3 = {d3, c3, b3, a3};
  assign y1 = (mode1 == 2'd0) ? hwt_model(vec1) :
              (mode1 == 2'd1) ? 1'b0 : ~hwt_model(vec1);
  assign y3 = hwt_model(vec3) ^ glitch3;

  hwt_sweep_ctrl #(.EXPECTED(16'h7800), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .hwt_y(y1),
    .hwt_a(a1), .hwt_b(b1), .hwt_c(c1), .hwt_d(d1),
    .busy(busy1), .done(done1), .pass(pass1),
    .signature(sig1), .fail_count(fc1), .first_fail(ff1)
  );

  hwt_sweep_ctrl #(.EXPECTED(16'h7800), .SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .hwt_y(y3),
    .hwt_a(a3), .hwt_b(b3), .hwt_c(c3), .hwt_d(d3),
    .busy(busy3), .done(done3), .pass(pass3),
    .signature(sig3), .fail_count(fc3), .first_fail(ff3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++;
    if ({busy1, done1, pass1, sig1, fc1, ff1, vec1} !== 32'h0) begin
      bad++;
      $display("FAIL reset_dut1 got=%h want=%h", {busy1, done1, pass1, sig1, fc1, ff1, vec1}, 32'h0);
    end
    total++;
    if ({busy3, done3, pass3, sig3, fc3, ff3, vec3} !== 32'h0) begin
      bad++;
      $display("FAIL reset_dut3 got=%h want=%h", {busy3, done3, pass3, sig3, fc3, ff3, vec3}, 32'h0);
    end
  endtask

  task automatic test_sweep1(input logic [1:0] m, input logic [15:0] es,
                             input logic [4:0] efc, input logic [3:0] eff,
                             input logic ep, input string name);
    logic [31:0] want;
    mode1  = m;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int v = 0; v < 16; v++) begin
      total++;
      if ({busy1, done1, vec1} !== {1'b1, 1'b0, 4'(v)}) begin
        bad++;
        $display("FAIL %s_step%0d got busy/done/vec=%b want=%b", name, v,
                 {busy1, done1, vec1}, {1'b1, 1'b0, 4'(v)});
      end
      tick();
    end
    want = {1'b0, 1'b1, ep, es, efc, eff, 4'h0};
    total++;
    if ({busy1, done1, pass1, sig1, fc1, ff1, vec1} !== want) begin
      bad++;
      $display("FAIL %s_done got=%h want=%h", name, {busy1, done1, pass1, sig1, fc1, ff1, vec1}, want);
    end
    tick();
    want = {1'b0, 1'b0, ep, es, efc, eff, 4'h0};
    total++;
    if ({busy1, done1, pass1, sig1, fc1, ff1, vec1} !== want) begin
      bad++;
      $display("FAIL %s_hold got=%h want=%h", name, {busy1, done1, pass1, sig1, fc1, ff1, vec1}, want);
    end
  endtask

  task automatic test_mid_reset();
    logic saw_done;
    mode1  = 2'd2;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (7) tick();
    total++;
    if ({vec1, sig1, fc1} !== {4'd7, 16'h007F, 5'd7}) begin
      bad++;
      $display("FAIL midrst_pre got vec/sig/fc=%h want=%h", {vec1, sig1, fc1}, {4'd7, 16'h007F, 5'd7});
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({busy1, done1, pass1, sig1, fc1, ff1, vec1} !== 32'h0) begin
      bad++;
      $display("FAIL midrst_clear got=%h want=%h", {busy1, done1, pass1, sig1, fc1, ff1, vec1}, 32'h0);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done1 !== 1'b0 || busy1 !== 1'b0) saw_done = 1'b1;
      tick();
    end
    total++;
    if (saw_done !== 1'b0) begin
      bad++;
      $display("FAIL midrst_quiet got activity=%b want=0", saw_done);
    end
    test_sweep1(2'd0, 16'h7800, 5'd0, 4'd0, 1'b1, "after_rst");
  endtask

  task automatic test_back_to_back();
    logic [31:0] want;
    mode1  = 2'd0;
    start1 = 1'b1;
    tick();
    for (int v = 0; v < 16; v++) begin
      total++;
      if ({busy1, done1, vec1} !== {1'b1, 1'b0, 4'(v)}) begin
        bad++;
        $display("FAIL b2b_first_step%0d got=%b want=%b", v, {busy1, done1, vec1}, {1'b1, 1'b0, 4'(v)});
      end
      tick();
    end
    want = {1'b0, 1'b1, 1'b1, 16'h7800, 5'd0, 4'd0, 4'h0};
    total++;
    if ({busy1, done1, pass1, sig1, fc1, ff1, vec1} !== want) begin
      bad++;
      $display("FAIL b2b_first_done got=%h want=%h", {busy1, done1, pass1, sig1, fc1, ff1, vec1}, want);
    end
    tick();
    mode1 = 2'd1;
    want = {1'b1, 1'b0, 1'b0, 16'h0000, 5'd0, 4'd0, 4'h0};
    total++;
    if ({busy1, done1, pass1, sig1, fc1, ff1, vec1} !== want) begin
      bad++;
      $display("FAIL b2b_restart got=%h want=%h", {busy1, done1, pass1, sig1, fc1, ff1, vec1}, want);
    end
    for (int v = 0; v < 16; v++) begin
      total++;
      if ({busy1, done1, vec1} !== {1'b1, 1'b0, 4'(v)}) begin
        bad++;
        $display("FAIL b2b_second_step%0d got=%b want=%b", v, {busy1, done1, vec1}, {1'b1, 1'b0, 4'(v)});
      end
      tick();
    end
    want = {1'b0, 1'b1, 1'b0, 16'h0000, 5'd4, 4'd11, 4'h0};
    total++;
    if ({busy1, done1, pass1, sig1, fc1, ff1, vec1} !== want) begin
      bad++;
      $display("FAIL b2b_second_done got=%h want=%h", {busy1, done1, pass1, sig1, fc1, ff1, vec1}, want);
    end
    start1 = 1'b0;
    tick();
    total++;
    if ({busy1, done1} !== 2'b00) begin
      bad++;
      $display("FAIL b2b_idle got busy/done=%b want=00", {busy1, done1});
    end
  endtask

  task automatic test_settle3();
    logic [31:0] want;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int k = 0; k < 48; k++) begin
      glitch3 = ((k % 3) != 2);
      total++;
      if ({busy3, done3, vec3} !== {1'b1, 1'b0, 4'(k / 3)}) begin
        bad++;
        $display("FAIL settle3_cycle%0d got=%b want=%b", k, {busy3, done3, vec3}, {1'b1, 1'b0, 4'(k / 3)});
      end
      tick();
    end
    glitch3 = 1'b0;
    want = {1'b0, 1'b1, 1'b1, 16'h7800, 5'd0, 4'd0, 4'h0};
    total++;
    if ({busy3, done3, pass3, sig3, fc3, ff3, vec3} !== want) begin
      bad++;
      $display("FAIL settle3_done got=%h want=%h", {busy3, done3, pass3, sig3, fc3, ff3, vec3}, want);
    end
    tick();
    total++;
    if (done3 !== 1'b0) begin
      bad++;
      $display("FAIL settle3_pulse got done=%b want=0", done3);
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b0;
    start1  = 1'b0;
    start3  = 1'b0;
    mode1   = 2'd0;
    glitch3 = 1'b0;
    test_reset();
    test_sweep1(2'd0, 16'h7800, 5'd0, 4'd0, 1'b1, "golden");
    test_sweep1(2'd1, 16'h0000, 5'd4, 4'd11, 1'b0, "stuck0");
    test_sweep1(2'd2, 16'h87FF, 5'd16, 4'd0, 1'b0, "inverted");
    test_settle3();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
